// File: rtl/sram_like_port_if.sv
`default_nettype none
// ============================================================================
// Module : sram_like_port_if
// Desc   : Pipeline-side, memory-side and downstream signals of sram_like_port.
// Rev    : 1.0 - initial release
// ============================================================================
interface sram_like_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 64
);
  // upstream request
  logic                  up_valid;
  logic                  up_allow_in;
  logic                  up_wr;
  logic [DATA_W/8-1:0]   up_wstrb;
  logic [ADDR_W-1:0]     up_addr;
  logic [DATA_W-1:0]     up_wdata;
  logic [TAG_W-1:0]      up_tag;
  logic                  flush;

  // memory port
  logic                  req;
  logic                  wr;
  logic [DATA_W/8-1:0]   wstrb;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  addr_ok;
  logic                  data_ok;
  logic [DATA_W-1:0]     rdata;

  // downstream response
  logic                  dn_valid;
  logic                  dn_allow_in;
  logic [DATA_W-1:0]     dn_rdata;
  logic                  dn_wr;
  logic [TAG_W-1:0]      dn_tag;
  logic                  busy;

  modport slave (
    input  up_valid, up_wr, up_wstrb, up_addr, up_wdata, up_tag, flush,
    input  addr_ok, data_ok, rdata, dn_allow_in,
    output up_allow_in, req, wr, wstrb, addr, wdata,
    output dn_valid, dn_rdata, dn_wr, dn_tag, busy
  );

  modport master (
    output up_valid, up_wr, up_wstrb, up_addr, up_wdata, up_tag, flush,
    output addr_ok, data_ok, rdata, dn_allow_in,
    input  up_allow_in, req, wr, wstrb, addr, wdata,
    input  dn_valid, dn_rdata, dn_wr, dn_tag, busy
  );
endinterface
`default_nettype wire

// File: rtl/sram_like_port.sv
`default_nettype none
// ============================================================================
// Module : sram_like_port
// Desc   : valid/allow_in stage to split-transaction (addr_ok/data_ok) SRAM bridge.
// Rev    : 1.0 - initial release
// ============================================================================
module sram_like_port #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 64,
  parameter int OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            resetn,
  sram_like_port_if.slave bus
);

  localparam int CNT_W  = $clog2(OUTSTANDING + 1);
  localparam int PTR_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int TENT_W = TAG_W + 1;
  localparam int RENT_W = DATA_W + TAG_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W:0]   DEPTH    = (CNT_W + 1)'(OUTSTANDING);

  if (ADDR_W < 1 || DATA_W < 8 || (DATA_W % 8) != 0 || TAG_W < 1 ||
      OUTSTANDING < 1 || OUTSTANDING > 8) begin : g_param_err
    $error("sram_like_port: illegal parameter combination");
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  cancel_q,   cancel_d;
  logic [CNT_W-1:0]  buf_cnt_q,  buf_cnt_d;
  logic [PTR_W-1:0]  tag_wp_q,   tag_wp_d;
  logic [PTR_W-1:0]  tag_rp_q,   tag_rp_d;
  logic [PTR_W-1:0]  rsp_wp_q,   rsp_wp_d;
  logic [PTR_W-1:0]  rsp_rp_q,   rsp_rp_d;

  logic [TENT_W-1:0] tag_mem_q [OUTSTANDING];
  logic [RENT_W-1:0] rsp_mem_q [OUTSTANDING];

  logic              credit;
  logic              accept;
  logic              rsp_valid;
  logic              rsp_keep;
  logic              dn_pop;
  logic [TENT_W-1:0] tag_head;
  logic [RENT_W-1:0] rsp_head;

  // Credit looks only at registered counts, so a pop frees a slot one cycle later.
  assign credit = ({1'b0, inflight_q} + {1'b0, buf_cnt_q}) < DEPTH;

  assign bus.req         = resetn & bus.up_valid & credit & ~bus.flush;
  assign bus.up_allow_in = bus.req & bus.addr_ok;
  assign bus.wr          = bus.up_wr;
  assign bus.wstrb       = bus.up_wstrb;
  assign bus.addr        = bus.up_addr;
  assign bus.wdata       = bus.up_wdata;

  assign accept    = bus.up_allow_in;
  // A data_ok with nothing in flight is a protocol violation and is ignored.
  assign rsp_valid = bus.data_ok & (inflight_q != '0);
  assign rsp_keep  = rsp_valid & ~bus.flush & (cancel_q == '0);
  assign dn_pop    = bus.dn_valid & bus.dn_allow_in & ~bus.flush;

  assign tag_head = tag_mem_q[tag_rp_q];
  assign rsp_head = rsp_mem_q[rsp_rp_q];

  assign bus.dn_valid = (buf_cnt_q != '0);
  assign bus.dn_rdata = bus.dn_valid ? rsp_head[RENT_W-1 -: DATA_W] : '0;
  assign bus.dn_tag   = bus.dn_valid ? rsp_head[TAG_W:1] : '0;
  assign bus.dn_wr    = bus.dn_valid & rsp_head[0];
  assign bus.busy     = (inflight_q != '0) | (cancel_q != '0) | (buf_cnt_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    cancel_d   = cancel_q;
    buf_cnt_d  = buf_cnt_q;
    tag_wp_d   = tag_wp_q;
    tag_rp_d   = tag_rp_q;
    rsp_wp_d   = rsp_wp_q;
    rsp_rp_d   = rsp_rp_q;

    if (accept && !rsp_valid) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!accept && rsp_valid) begin
      inflight_d = inflight_q - CNT_W'(1);
    end

    if (accept) begin
      tag_wp_d = ptr_inc(tag_wp_q);
    end
    if (rsp_valid) begin
      tag_rp_d = ptr_inc(tag_rp_q);
    end

    // Flush recomputes the cancel count from what is still outstanding.
    if (bus.flush) begin
      cancel_d = rsp_valid ? (inflight_q - CNT_W'(1)) : inflight_q;
    end else if (rsp_valid && (cancel_q != '0)) begin
      cancel_d = cancel_q - CNT_W'(1);
    end

    if (bus.flush) begin
      buf_cnt_d = '0;
      rsp_wp_d  = '0;
      rsp_rp_d  = '0;
    end else begin
      if (rsp_keep) begin
        rsp_wp_d = ptr_inc(rsp_wp_q);
      end
      if (dn_pop) begin
        rsp_rp_d = ptr_inc(rsp_rp_q);
      end
      if (rsp_keep && !dn_pop) begin
        buf_cnt_d = buf_cnt_q + CNT_W'(1);
      end else if (!rsp_keep && dn_pop) begin
        buf_cnt_d = buf_cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight_q <= '0;
      cancel_q   <= '0;
      buf_cnt_q  <= '0;
      tag_wp_q   <= '0;
      tag_rp_q   <= '0;
      rsp_wp_q   <= '0;
      rsp_rp_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      cancel_q   <= cancel_d;
      buf_cnt_q  <= buf_cnt_d;
      tag_wp_q   <= tag_wp_d;
      tag_rp_q   <= tag_rp_d;
      rsp_wp_q   <= rsp_wp_d;
      rsp_rp_q   <= rsp_rp_d;
    end
  end

  // Storage needs no reset: every read of it is qualified by a nonzero count.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_mem_q[tag_wp_q] <= {bus.up_tag, bus.up_wr};
    end
    if (rsp_keep) begin
      rsp_mem_q[rsp_wp_q] <= {bus.rdata, tag_head};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_port.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_like_port
// Desc   : Scoreboard bench for sram_like_port with a one-cycle memory model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sram_like_port;

  typedef struct {
    logic [63:0] tag;
    logic        wr;
    logic [31:0] rdata;
    logic        drop;
    int          due;
  } mem_t;

  typedef struct {
    logic [63:0] tag;
    logic        wr;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic resetn;

  sram_like_port_if #(.ADDR_W(32), .DATA_W(32), .TAG_W(64)) bus ();

  sram_like_port #(
    .ADDR_W(32), .DATA_W(32), .TAG_W(64), .OUTSTANDING(2)
  ) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  mem_t mem_q[$];
  exp_t exp_q[$];
  int   n_chk;
  int   n_fail;
  int   n_rsp;
  int   cyc;
  logic mem_hold;
  logic stray;
  logic last_req;
  logic last_acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5C3_0F00 ^ {a[15:0], 16'h0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: entered just after a negedge with inputs already set.
  task automatic step();
    exp_t e;
    mem_t m;
    logic dok;
    dok = 1'b0;
    if (stray) begin
      dok = 1'b1;
    end else if (!mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      dok = 1'b1;
    end
    bus.data_ok = dok;
    bus.rdata   = (!stray && mem_q.size() > 0) ? mem_q[0].rdata : 32'hDEAD_BEEF;
    #1;
    last_req = bus.req;
    last_acc = bus.up_allow_in;
    check("dn_valid", bus.dn_valid, exp_q.size() != 0);
    check("busy", bus.busy, (mem_q.size() != 0) || (exp_q.size() != 0));
    if (bus.dn_valid && bus.dn_allow_in && !bus.flush && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_rsp++;
      check("dn_tag", bus.dn_tag, e.tag);
      check("dn_wr", bus.dn_wr, e.wr);
      if (!e.wr) check("dn_rdata", bus.dn_rdata, e.rdata);
    end
    if (bus.flush) exp_q.delete();
    if (dok && !stray) begin
      m = mem_q.pop_front();
      if (!m.drop && !bus.flush) exp_q.push_back('{tag: m.tag, wr: m.wr, rdata: m.rdata});
    end
    if (bus.flush) begin
      foreach (mem_q[i]) mem_q[i].drop = 1'b1;
    end
    if (last_acc) begin
      check("port_wr", bus.wr, bus.up_wr);
      check("port_addr", bus.addr, bus.up_addr);
      if (bus.up_wr) begin
        check("port_wstrb", bus.wstrb, bus.up_wstrb);
        check("port_wdata", bus.wdata, bus.up_wdata);
      end
      mem_q.push_back('{tag: bus.up_tag, wr: bus.up_wr, rdata: mem_data(bus.up_addr),
                        drop: 1'b0, due: cyc + 1});
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    bus.data_ok = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic [3:0] strb, input logic [31:0] a,
                       input logic [31:0] wd, input logic [63:0] tag);
    int n;
    n = 0;
    bus.up_valid = 1'b1;
    bus.up_wr    = wr;
    bus.up_wstrb = strb;
    bus.up_addr  = a;
    bus.up_wdata = wd;
    bus.up_tag   = tag;
    do begin
      step();
      n++;
    end while (!last_acc && n < 40);
    check("issue_accept", last_acc, 1'b1);
    bus.up_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mem_q.size() != 0 || exp_q.size() != 0) && n < 60) begin
      step();
      n++;
    end
    check("drain", (mem_q.size() == 0) && (exp_q.size() == 0), 1'b1);
  endtask

  initial begin
    int base;
    n_chk = 0; n_fail = 0; n_rsp = 0; cyc = 0;
    mem_hold = 1'b0; stray = 1'b0;
    resetn = 1'b0;
    bus.up_valid = 1'b1; bus.up_wr = 1'b0; bus.up_wstrb = '0;
    bus.up_addr = '0; bus.up_wdata = '0; bus.up_tag = '0;
    bus.flush = 1'b0; bus.addr_ok = 1'b1; bus.data_ok = 1'b0;
    bus.rdata = '0; bus.dn_allow_in = 1'b1;

    @(negedge clk); #1;
    check("rst_req", bus.req, 1'b0);
    check("rst_allow", bus.up_allow_in, 1'b0);
    check("rst_dn_valid", bus.dn_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_dn_tag", bus.dn_tag, 64'h0);
    bus.up_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // back-to-back reads
    base = n_rsp;
    issue(1'b0, 4'h0, 32'h00, 32'h0, 64'd1);
    issue(1'b0, 4'h0, 32'h04, 32'h0, 64'd2);
    issue(1'b0, 4'h0, 32'h08, 32'h0, 64'd3);
    wait_idle();
    check("s1_rsp_cnt", 64'(n_rsp - base), 64'd3);

    // downstream stall fills the buffer and withholds credit
    bus.dn_allow_in = 1'b0;
    issue(1'b0, 4'h0, 32'h10, 32'h0, 64'h21);
    issue(1'b0, 4'h0, 32'h14, 32'h0, 64'h22);
    step(); step(); step();
    bus.up_valid = 1'b1; bus.up_wr = 1'b0; bus.up_addr = 32'h18; bus.up_tag = 64'h23;
    step();
    check("s2_req_stalled", last_req, 1'b0);
    bus.dn_allow_in = 1'b1;
    step();
    check("s2_req_pop_cycle", last_req, 1'b0);
    step();
    check("s2_reaccept", last_acc, 1'b1);
    bus.up_valid = 1'b0;
    wait_idle();

    // flush with two in flight, second flush recomputes cancel count
    base = n_rsp;
    mem_hold = 1'b1;
    issue(1'b0, 4'h0, 32'h20, 32'h0, 64'h31);
    issue(1'b0, 4'h0, 32'h24, 32'h0, 64'h32);
    step();
    bus.flush = 1'b1;
    step();
    check("s3_flush_req", last_req, 1'b0);
    bus.flush = 1'b0; mem_hold = 1'b0;
    step();
    mem_hold = 1'b1; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; mem_hold = 1'b0;
    wait_idle();
    issue(1'b0, 4'h0, 32'h28, 32'h0, 64'h33);
    wait_idle();
    check("s3_rsp_cnt", 64'(n_rsp - base), 64'd1);

    // flush coinciding with data_ok, two in flight
    mem_hold = 1'b1;
    issue(1'b0, 4'h0, 32'h30, 32'h0, 64'h41);
    issue(1'b0, 4'h0, 32'h34, 32'h0, 64'h42);
    step();
    mem_hold = 1'b0; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    wait_idle();

    // flush with one in flight, one buffered, data_ok and dn_allow_in together
    base = n_rsp;
    bus.dn_allow_in = 1'b0;
    issue(1'b0, 4'h0, 32'h38, 32'h0, 64'h43);
    step();
    mem_hold = 1'b1;
    issue(1'b0, 4'h0, 32'h3C, 32'h0, 64'h44);
    step();
    mem_hold = 1'b0; bus.flush = 1'b1; bus.dn_allow_in = 1'b1;
    step();
    bus.flush = 1'b0;
    wait_idle();
    step(); step();
    check("s4_rsp_cnt", 64'(n_rsp - base), 64'd0);

    // write then read
    base = n_rsp;
    issue(1'b1, 4'b0011, 32'h40, 32'h1234_5678, 64'h51);
    issue(1'b0, 4'h0, 32'h40, 32'h0, 64'h52);
    wait_idle();
    check("s5_rsp_cnt", 64'(n_rsp - base), 64'd2);

    // asynchronous reset mid-operation, then a stray data_ok
    bus.dn_allow_in = 1'b0;
    issue(1'b0, 4'h0, 32'h60, 32'h0, 64'h61);
    step();
    mem_hold = 1'b1;
    issue(1'b0, 4'h0, 32'h64, 32'h0, 64'h62);
    check("s6_pre_busy", bus.busy, 1'b1);
    bus.up_valid = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("s6_req", bus.req, 1'b0);
    check("s6_allow", bus.up_allow_in, 1'b0);
    check("s6_dn_valid", bus.dn_valid, 1'b0);
    check("s6_busy", bus.busy, 1'b0);
    check("s6_dn_tag", bus.dn_tag, 64'h0);
    check("s6_dn_rdata", bus.dn_rdata, 64'h0);
    check("s6_dn_wr", bus.dn_wr, 1'b0);
    bus.up_valid = 1'b0;
    @(negedge clk);
    mem_q.delete();
    exp_q.delete();
    resetn = 1'b1;
    mem_hold = 1'b0;
    bus.dn_allow_in = 1'b1;
    stray = 1'b1;
    step();
    stray = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
